// File: rtl/pc_gen_bpred_pkg.sv
// Shared definitions for the fetch-address / branch-prediction stage.
`ifndef PC_GEN_BPRED_PKG_SV
`define PC_GEN_BPRED_PKG_SV

// Field extraction from a PC.
// pc[1:0] is always zero for aligned fetch, so every table indexes from bit 2.
`define BhtIndex(pc, IW)     pc[(IW)+1:2]
`define BtbIndex(pc, IW)     pc[(IW)+1:2]
`define BtbTag(pc, AW, IW)   pc[(AW)-1:(IW)+2]

package pc_gen_bpred_pkg;

   localparam int ADDR_BUS_W    = 32;
   localparam int BHT_IDX_W_DEF = 8;
   localparam int BTB_IDX_W_DEF = 6;

   typedef logic [ADDR_BUS_W-1:0] addr_bus_t;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_e;

   // Saturating 2-bit counter step toward the resolved direction.
   function automatic ctr_e ctr_update(input ctr_e c, input logic taken);
      ctr_e r;
      r = c;
      if (taken && c != STRONG_T)
         r = ctr_e'(c + 2'd1);
      else if (!taken && c != STRONG_NT)
         r = ctr_e'(c - 2'd1);
      return r;
   endfunction

endpackage

`endif

// File: rtl/bpred_table.sv
// BHT (2-bit counters) + direct-mapped BTB storage with a combinational
// lookup port and a synchronous training port. Lookup sees pre-write contents.
module bpred_table
   import pc_gen_bpred_pkg::*;
#(
   parameter int ADDR_W    = ADDR_BUS_W,
   parameter int BHT_IDX_W = BHT_IDX_W_DEF,
   parameter int BTB_IDX_W = BTB_IDX_W_DEF
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              lookup_hit,
   output logic              lookup_dir,
   output logic [ADDR_W-1:0] lookup_target,
   input  logic              train_valid,
   input  logic [ADDR_W-1:0] train_pc,
   input  logic              train_taken,
   input  logic [ADDR_W-1:0] train_target
);

   localparam int BHT_N = 1 << BHT_IDX_W;
   localparam int BTB_N = 1 << BTB_IDX_W;
   localparam int TAG_W = ADDR_W - BTB_IDX_W - 2;

   ctr_e              bht        [BHT_N];
   logic [BTB_N-1:0]  btb_valid;
   logic [TAG_W-1:0]  btb_tag    [BTB_N];
   logic [ADDR_W-1:0] btb_target [BTB_N];

   logic [BHT_IDX_W-1:0] lk_bht_idx, tr_bht_idx;
   logic [BTB_IDX_W-1:0] lk_btb_idx, tr_btb_idx;
   logic [TAG_W-1:0]     lk_tag, tr_tag;
   logic                 unused_lsb;

   assign lk_bht_idx = `BhtIndex(lookup_pc, BHT_IDX_W);
   assign lk_btb_idx = `BtbIndex(lookup_pc, BTB_IDX_W);
   assign lk_tag     = `BtbTag(lookup_pc, ADDR_W, BTB_IDX_W);
   assign tr_bht_idx = `BhtIndex(train_pc, BHT_IDX_W);
   assign tr_btb_idx = `BtbIndex(train_pc, BTB_IDX_W);
   assign tr_tag     = `BtbTag(train_pc, ADDR_W, BTB_IDX_W);
   assign unused_lsb = ^{lookup_pc[1:0], train_pc[1:0]};

   assign lookup_hit    = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
   assign lookup_dir    = bht[lk_bht_idx][1];
   assign lookup_target = btb_target[lk_btb_idx];

   // Direction counters: reset to weakly not-taken, step on every resolution.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int k = 0; k < BHT_N; k++) bht[k] <= WEAK_NT;
      end else if (rdy_in && train_valid) begin
         bht[tr_bht_idx] <= ctr_update(bht[tr_bht_idx], train_taken);
      end
   end

   // BTB valid bits: only taken resolutions allocate/overwrite an entry.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         btb_valid <= '0;
      else if (rdy_in && train_valid && train_taken)
         btb_valid[tr_btb_idx] <= 1'b1;
   end

   // BTB tag/target payload; gated by valid so it needs no reset.
   always_ff @(posedge clk_in) begin
      if (rdy_in && train_valid && train_taken) begin
         btb_tag[tr_btb_idx]    <= tr_tag;
         btb_target[tr_btb_idx] <= train_target;
      end
   end

endmodule

// File: rtl/pc_gen_bpred.sv
// Fetch PC register with BHT/BTB prediction, mispredict redirect and stall hold.
module pc_gen_bpred
   import pc_gen_bpred_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_BUS_W,
   parameter int                BHT_IDX_W = BHT_IDX_W_DEF,
   parameter int                BTB_IDX_W = BTB_IDX_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              stall_in,
   input  logic              ex_br_valid_in,
   input  logic [ADDR_W-1:0] ex_br_pc_in,
   input  logic              ex_br_taken_in,
   input  logic [ADDR_W-1:0] ex_br_target_in,
   input  logic              ex_mispredict_in,
   input  logic [ADDR_W-1:0] ex_correct_pc_in,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] next_pc_out,
   output logic              branch_taken_out
);

   logic [ADDR_W-1:0] pc;
   logic              lk_hit, lk_dir;
   logic [ADDR_W-1:0] lk_target;

   bpred_table #(
      .ADDR_W    (ADDR_W),
      .BHT_IDX_W (BHT_IDX_W),
      .BTB_IDX_W (BTB_IDX_W)
   ) u_table (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .lookup_pc     (pc),
      .lookup_hit    (lk_hit),
      .lookup_dir    (lk_dir),
      .lookup_target (lk_target),
      .train_valid   (ex_br_valid_in),
      .train_pc      (ex_br_pc_in),
      .train_taken   (ex_br_taken_in),
      .train_target  (ex_br_target_in)
   );

   // Taken only when the BTB knows where to go; pc+4 wraps naturally.
   assign branch_taken_out = lk_hit && lk_dir;
   assign next_pc_out      = branch_taken_out ? lk_target : pc + ADDR_W'(4);
   assign pc_out           = pc;

   // PC update: redirect beats stall, stall beats sequential/predicted advance.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         pc <= RESET_PC;
      else if (rdy_in) begin
         if (ex_mispredict_in)
            pc <= ex_correct_pc_in;
         else if (!stall_in)
            pc <= next_pc_out;
      end
   end

endmodule

// File: tb/tb_pc_gen_bpred.sv
// Randomized + directed bench for pc_gen_bpred against an array-based model.
module tb_pc_gen_bpred;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        stall_in = 1'b0;
   logic        ex_br_valid_in = 1'b0;
   logic [31:0] ex_br_pc_in = '0;
   logic        ex_br_taken_in = 1'b0;
   logic [31:0] ex_br_target_in = '0;
   logic        ex_mispredict_in = 1'b0;
   logic [31:0] ex_correct_pc_in = '0;
   logic [31:0] pc_out, next_pc_out;
   logic        branch_taken_out;

   int n_pass = 0;
   int n_total = 0;
   bit cmp_en = 0;

   pc_gen_bpred dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .stall_in         (stall_in),
      .ex_br_valid_in   (ex_br_valid_in),
      .ex_br_pc_in      (ex_br_pc_in),
      .ex_br_taken_in   (ex_br_taken_in),
      .ex_br_target_in  (ex_br_target_in),
      .ex_mispredict_in (ex_mispredict_in),
      .ex_correct_pc_in (ex_correct_pc_in),
      .pc_out           (pc_out),
      .next_pc_out      (next_pc_out),
      .branch_taken_out (branch_taken_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int          m_bht [256];
   bit          m_v   [64];
   logic [23:0] m_tag [64];
   logic [31:0] m_tgt [64];
   logic [31:0] m_pc;

   function automatic void predict(output logic taken, output logic [31:0] nxt);
      int bi, ti;
      bi = int'(m_pc[9:2]);
      ti = int'(m_pc[7:2]);
      taken = m_v[ti] && (m_tag[ti] == m_pc[31:8]) && (m_bht[bi] >= 2);
      nxt = taken ? m_tgt[ti] : m_pc + 32'd4;
   endfunction

   always @(posedge clk_in or negedge rst_in) begin
      logic        t;
      logic [31:0] n;
      int          bi, ti;
      if (!rst_in) begin
         m_pc = 32'h0;
         for (int k = 0; k < 256; k++) m_bht[k] = 1;
         for (int k = 0; k < 64; k++) m_v[k] = 0;
      end else if (rdy_in) begin
         predict(t, n);
         if (ex_mispredict_in) m_pc = ex_correct_pc_in;
         else if (!stall_in) m_pc = n;
         if (ex_br_valid_in) begin
            bi = int'(ex_br_pc_in[9:2]);
            ti = int'(ex_br_pc_in[7:2]);
            if (ex_br_taken_in) begin
               if (m_bht[bi] < 3) m_bht[bi]++;
               m_v[ti] = 1;
               m_tag[ti] = ex_br_pc_in[31:8];
               m_tgt[ti] = ex_br_target_in;
            end else if (m_bht[bi] > 0) m_bht[bi]--;
         end
      end
   end

   // Compare process: every falling edge once enabled.
   always @(negedge clk_in) begin
      logic        t;
      logic [31:0] n;
      if (cmp_en) begin
         predict(t, n);
         chk("model_pc", pc_out, m_pc);
         chk("model_next_pc", next_pc_out, n);
         chk("model_taken", {31'b0, branch_taken_out}, {31'b0, t});
      end
   end

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clr_ex();
      ex_br_valid_in = 0; ex_br_taken_in = 0; ex_mispredict_in = 0;
   endtask

   task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      ex_br_valid_in = 1; ex_br_pc_in = pc; ex_br_taken_in = tk; ex_br_target_in = tgt;
      cyc();
      ex_br_valid_in = 0;
   endtask

   task automatic redirect(input logic [31:0] pc);
      ex_mispredict_in = 1; ex_correct_pc_in = pc;
      cyc();
      ex_mispredict_in = 0;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_next", next_pc_out, 32'h4);
      chk("rst_taken", {31'b0, branch_taken_out}, 32'h0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1;
      cmp_en = 1;
      #1;
      // free run from empty tables
      chk("run_pc0", pc_out, 32'h0);
      for (int i = 1; i <= 3; i++) begin
         cyc();
         chk("run_pc", pc_out, 32'(4 * i));
         chk("run_taken", {31'b0, branch_taken_out}, 32'h0);
      end
      cyc();
      chk("run_pc10", pc_out, 32'h10);
      // stall hold
      stall_in = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_hold", pc_out, 32'h10);
      end
      stall_in = 0;
      cyc();
      chk("stall_release", pc_out, 32'h14);
      // mispredict overrides stall
      stall_in = 1;
      redirect(32'h200);
      chk("misp_under_stall", pc_out, 32'h200);
      // one taken training then fetch at 0x40 (redirect same cycle)
      ex_br_valid_in = 1; ex_br_pc_in = 32'h40; ex_br_taken_in = 1; ex_br_target_in = 32'h100;
      redirect(32'h40);
      clr_ex();
      chk("bp_taken", {31'b0, branch_taken_out}, 32'h1);
      chk("bp_next", next_pc_out, 32'h100);
      stall_in = 0;
      cyc();
      chk("bp_follow", pc_out, 32'h100);
      // two not-taken -> counter 00
      stall_in = 1;
      train(32'h40, 0, 32'h0);
      train(32'h40, 0, 32'h0);
      redirect(32'h40);
      chk("nt_taken", {31'b0, branch_taken_out}, 32'h0);
      chk("nt_next", next_pc_out, 32'h44);
      // saturate at 11, one not-taken keeps taken
      for (int i = 0; i < 4; i++) train(32'h40, 1, 32'h100);
      train(32'h40, 0, 32'h0);
      chk("sat_taken", {31'b0, branch_taken_out}, 32'h1);
      chk("sat_next", next_pc_out, 32'h100);
      // BTB alias: 0x140 evicts 0x40's entry
      train(32'h140, 1, 32'h300);
      chk("alias_taken", {31'b0, branch_taken_out}, 32'h0);
      chk("alias_next", next_pc_out, 32'h44);
      // wraparound
      redirect(32'hFFFF_FFFC);
      chk("wrap_next", next_pc_out, 32'h0);
      stall_in = 0;
      cyc();
      chk("wrap_pc", pc_out, 32'h0);
      // rdy_in=0 freezes everything, including redirect
      rdy_in = 0;
      ex_br_valid_in = 1; ex_br_pc_in = 32'h0; ex_br_taken_in = 1; ex_br_target_in = 32'h800;
      redirect(32'h500);
      clr_ex();
      chk("rdy_hold_pc", pc_out, 32'h0);
      chk("rdy_hold_next", next_pc_out, 32'h4);
      rdy_in = 1;
      // randomized phase
      for (int c = 0; c < 3000; c++) begin
         rdy_in           = ($urandom_range(0, 15) != 0);
         stall_in         = ($urandom_range(0, 3) == 0);
         ex_br_valid_in   = $urandom_range(0, 1);
         ex_br_pc_in      = {20'($urandom_range(0, 3)), 12'($urandom_range(0, 127) << 2)};
         ex_br_taken_in   = $urandom_range(0, 1);
         ex_br_target_in  = {20'($urandom_range(0, 3)), 12'($urandom_range(0, 127) << 2)};
         ex_mispredict_in = ($urandom_range(0, 7) == 0);
         ex_correct_pc_in = {20'($urandom_range(0, 3)), 12'($urandom_range(0, 127) << 2)};
         if (c == 1500) begin
            // async reset mid-run, checked before any clock edge
            rst_in = 0;
            #1;
            chk("mid_rst_pc", pc_out, 32'h0);
            chk("mid_rst_next", next_pc_out, 32'h4);
            chk("mid_rst_taken", {31'b0, branch_taken_out}, 32'h0);
            @(posedge clk_in);
            #2;
            rst_in = 1;
         end
         cyc();
      end
      clr_ex();
      cyc();
      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pc_gen_bpred.md
Name: pc_gen_bpred

Overview:
- Fetch-address stage directly upstream of the instruction-fetch/icache stage.
- Holds the architectural fetch PC and presents it every cycle with a predicted successor PC and a predicted-taken flag.
- Prediction uses a 2-bit saturating-counter BHT plus a direct-mapped BTB, both trained by branch resolutions from EX.
- Redirects to the correct PC on a mispredict; holds while fetch is stalled.

Parameters:
- ADDR_W, 32, address width.
- BHT_IDX_W, 8, log2 BHT entries (256); index = pc[BHT_IDX_W+1:2].
- BTB_IDX_W, 6, log2 BTB entries (64); index = pc[BTB_IDX_W+1:2]; tag = pc[ADDR_W-1:BTB_IDX_W+2].
- RESET_PC, 0, fetch address after reset.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; 0 freezes all state.
- stall_in  in  1  fetch not done this cycle (IF miss or downstream stall); hold PC.
- ex_br_valid_in  in  1  EX resolved a control-flow instruction this cycle.
- ex_br_pc_in  in  ADDR_W  PC of the resolved instruction.
- ex_br_taken_in  in  1  actual direction (jal/jalr report 1).
- ex_br_target_in  in  ADDR_W  actual taken target.
- ex_mispredict_in  in  1  fetch path wrong; flush and redirect.
- ex_correct_pc_in  in  ADDR_W  redirect address, valid with ex_mispredict_in.
- pc_out  out  ADDR_W  current fetch PC.
- next_pc_out  out  ADDR_W  predicted successor of pc_out.
- branch_taken_out  out  1  prediction for pc_out is taken.

Behaviour:
- Reset (rst_in=0, async): pc = RESET_PC; every BHT counter = 2'b01 (weakly not-taken); every BTB valid = 0. Outputs during reset: pc_out = RESET_PC, next_pc_out = RESET_PC+4, branch_taken_out = 0.
- Lookup is combinational from pc, with zero latency:
  - hit = btb_valid[i] && btb_tag[i] == tag(pc);
  - branch_taken_out = hit && bht[j][1];
  - next_pc_out = branch_taken_out ? btb_target[i] : pc+4.
  - pc+4 wraps modulo 2^ADDR_W.
- PC update on posedge when rdy_in=1, in priority order:
  1. ex_mispredict_in=1: pc <= ex_correct_pc_in. Applies even when stall_in=1.
  2. Else stall_in=1: pc holds.
  3. Else: pc <= next_pc_out.
- rdy_in=0: PC, BHT and BTB all hold. EX inputs are ignored that cycle; EX must hold them.
- Training on posedge when rdy_in=1 and ex_br_valid_in=1, independent of stall_in:
  - BHT[idx(ex_br_pc_in)]: taken increments, saturating at 11; not-taken decrements, saturating at 00.
  - If taken: BTB[idx] <= {valid=1, tag(ex_br_pc_in), ex_br_target_in}, overwriting any previous occupant.
  - If not taken: BTB is unchanged.
- Simultaneous train and lookup at the same index: lookup sees the pre-update contents; the new value is visible next cycle.
- Mispredict and training in the same cycle are both performed.
- Reset asserted mid-operation takes effect immediately. Table contents are not preserved.
- Tables are plain register arrays. The write ports are synchronous; the BHT read is async.

Decomposition:
- Shared defines package:
  - AddressBus width;
  - BHT/BTB index and tag bit-range macros (BhtIndex, BtbIndex, BtbTag);
  - counter encodings STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
- Sub-module bpred_table: BHT + BTB storage, combinational lookup port, training port.
- The parent holds the PC register and the redirect/stall priority logic.

Test Plan:
- Reset then free run, no stall, empty tables -> pc_out 0,4,8,12 on successive cycles; branch_taken_out=0 throughout.
- stall_in=1 for 3 cycles at pc=0x10 -> pc_out stays 0x10 for all 3; next cycle 0x14.
- ex_mispredict_in=1 with ex_correct_pc_in=0x200 while stall_in=1 -> pc_out=0x200 next cycle.
- Train pc=0x40 taken, target=0x100, once -> counter 10, BTB hit. Fetch at 0x40 -> branch_taken_out=1, next_pc_out=0x100, pc_out=0x100 next cycle.
- Train 0x40 not-taken twice after the above -> counter 00; fetch 0x40 predicts next_pc_out=0x44. Four taken trainings saturate at 11, and one not-taken then still predicts taken.
- BTB alias: train 0x40 to 0x100, then 0x140 (same index) to 0x300 -> fetch at 0x40 misses tag, next 0x44. Also pc=0xFFFFFFFC with empty tables -> next_pc_out=0x0.
